pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
Central pipeline sequencer for the 5-stage core (F, D, E, M, W). Collects stall and redirect requests: load-use hazard from the D stage, branch resolution from E, the multicycle mul/div unit in E, the data-memory handshake in M, and traps. Drives per-stage stall and per-boundary flush/bubble controls, including the flush input of the D stage. Contains a 3-state FSM, a mul/div timeout counter and a saturating stall-cycle performance counter.

Parameters:
MD_TIMEOUT, 64, max cycles spent in MD_WAIT before abort (>=2)
CNT_W, 32, width of stall performance counter

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
ld_use  in  1  load-use hazard request from D-stage hazard unit
br_taken  in  1  E-stage branch/jump resolved taken
br_target  in  32  E-stage redirect target
md_start  in  1  valid mul/div op present in E
md_done  in  1  mul/div result valid this cycle
dmem_req  in  1  M-stage memory access valid
dmem_ready  in  1  data memory accepts/returns this cycle
trap  in  1  trap request; vector supplied on trap_vec
trap_vec  in  32  trap target PC
f_stall  out  1  hold PC / F-D register
d_stall  out  1  hold D stage
e_stall  out  1  hold D-E register
m_stall  out  1  hold E-M register
fd_flush  out  1  kill instruction entering D
de_flush  out  1  bubble into D-E register (D-stage flush)
em_bubble  out  1  bubble into E-M register
mw_bubble  out  1  bubble into M-W register
pc_redirect  out  1  load PC from redirect_pc
redirect_pc  out  32  redirect target
md_abort  out  1  one-cycle pulse: cancel mul/div unit
md_err  out  1  sticky: mul/div timeout occurred
state  out  2  FSM state (RUN=0, MD_WAIT=1, MEM_WAIT=2)
stall_cnt  out  CNT_W  cycles with f_stall=1, saturating

Behaviour:
- Reset (rst_n low, async): state=RUN, md_cnt=0, md_err=0, stall_cnt=0. All combinational outputs forced to 0 while rst_n low; redirect_pc=0.
- Stall/flush/redirect outputs are combinational from state and inputs (same-cycle). State, md_cnt, md_err and stall_cnt are registered.
- Default when no condition applies: all outputs 0.
- RUN, first matching rule wins:
  1. dmem_req & ~dmem_ready: f/d/e/m_stall=1, mw_bubble=1; next MEM_WAIT.
  2. trap: pc_redirect=1, redirect_pc=trap_vec, fd_flush=de_flush=em_bubble=1; stay RUN.
  3. md_start & ~md_done: f/d/e_stall=1, em_bubble=1; md_cnt<=1; next MD_WAIT.
  4. br_taken: pc_redirect=1, redirect_pc=br_target, fd_flush=de_flush=1, no stall.
  5. ld_use: f_stall=d_stall=1, de_flush=1.
  - md_start & md_done in RUN (single-cycle op): falls through to rule 4/5.
- MD_WAIT:
  - trap: md_abort=1, redirect as RUN rule 2; next RUN.
  - Else md_done: f/d/e_stall=1, em_bubble=1; next RUN. The E op advances next cycle.
  - Else if md_cnt==MD_TIMEOUT-1: md_abort=1, md_err<=1, stalls as above; next RUN.
  - Else: f/d/e_stall=1, em_bubble=1, md_cnt<=md_cnt+1.
  - br_taken, ld_use and dmem_req are ignored. M holds a bubble, so dmem_req=1 here is a protocol error and is flagged by a bench assertion.
- MEM_WAIT:
  - f/d/e/m_stall=1, mw_bubble=1 every cycle, including the dmem_ready cycle.
  - dmem_ready: next RUN.
  - trap, br_taken, md_start and ld_use are ignored; their sources hold them and they are re-evaluated in RUN.
- Invalid state encoding (3): behaves as RUN; next RUN.
- stall_cnt: increments each cycle f_stall=1; holds at 2^CNT_W-1.
- md_err: clears only on reset.

Test Plan:
- Load-use: RUN, ld_use=1 for 1 cycle -> f_stall=d_stall=de_flush=1 that cycle only; state stays 0; stall_cnt=1.
- Branch + load-use same cycle: br_taken=1, br_target=0x80, ld_use=1 -> pc_redirect=1, redirect_pc=0x80, fd_flush=de_flush=1, f_stall=0; stall_cnt unchanged.
- Mul/div: md_start=1 at cycle 0, md_done=1 at cycle 4 -> state=1 for cycles 1-4, f/d/e_stall=em_bubble=1 for cycles 0-4, state=0 at cycle 5; stall_cnt=5.
- Timeout with MD_TIMEOUT=4: md_start=1, md_done never asserted -> md_abort pulses in the 4th cycle of the op, md_err=1 afterwards, state returns to 0.
- Memory wait vs. branch: dmem_req=1, dmem_ready=0 for 3 cycles with br_taken=1 held -> all four stalls=1, mw_bubble=1, pc_redirect=0, state=2. On the ready cycle, still stalled; next cycle pc_redirect=1.
- Trap during MD_WAIT, plus reset: trap=1, trap_vec=0x100 in cycle 2 of MD_WAIT -> md_abort=1, pc_redirect=1, redirect_pc=0x100, fd_flush=de_flush=em_bubble=1, next state=0. Then asserting rst_n=0 mid-MEM_WAIT -> state=0, all outputs 0 immediately, stall_cnt=0.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer for the 5-stage core: merges hazard, branch, mul/div, memory
// and trap requests into per-stage stall, flush and redirect controls.
module pipe_ctrl #(
    parameter int MD_TIMEOUT = 64,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ld_use,
    input  logic             br_taken,
    input  logic [31:0]      br_target,
    input  logic             md_start,
    input  logic             md_done,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    input  logic             trap,
    input  logic [31:0]      trap_vec,
    output logic             f_stall,
    output logic             d_stall,
    output logic             e_stall,
    output logic             m_stall,
    output logic             fd_flush,
    output logic             de_flush,
    output logic             em_bubble,
    output logic             mw_bubble,
    output logic             pc_redirect,
    output logic [31:0]      redirect_pc,
    output logic             md_abort,
    output logic             md_err,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MD_WAIT  = 2'd1,
        MEM_WAIT = 2'd2,
        ST_BAD   = 2'd3
    } state_t;

    localparam int              MD_W    = $clog2(MD_TIMEOUT) + 1;
    localparam logic [MD_W-1:0] MD_LAST = MD_W'(MD_TIMEOUT - 1);

    state_t          state_q, state_d;
    logic [MD_W-1:0] md_cnt_q, md_cnt_d;
    logic            md_err_q, md_err_d;

    // NOTE: registers use non-blocking assignments so every flop samples the
    // pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RUN;
            md_cnt_q  <= '0;
            md_err_q  <= 1'b0;
            stall_cnt <= '0;
        end else begin
            state_q  <= state_d;
            md_cnt_q <= md_cnt_d;
            md_err_q <= md_err_d;
            if (f_stall && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 1'b1;
        end
    end

    // NOTE: every signal written below gets a default first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    always_comb begin
        f_stall     = 1'b0;
        d_stall     = 1'b0;
        e_stall     = 1'b0;
        m_stall     = 1'b0;
        fd_flush    = 1'b0;
        de_flush    = 1'b0;
        em_bubble   = 1'b0;
        mw_bubble   = 1'b0;
        pc_redirect = 1'b0;
        redirect_pc = '0;
        md_abort    = 1'b0;
        state_d     = state_q;
        md_cnt_d    = md_cnt_q;
        md_err_d    = md_err_q;

        if (rst_n) begin
            case (state_q)
                MD_WAIT: begin
                    if (trap) begin
                        md_abort    = 1'b1;
                        pc_redirect = 1'b1;
                        redirect_pc = trap_vec;
                        fd_flush    = 1'b1;
                        de_flush    = 1'b1;
                        em_bubble   = 1'b1;
                        state_d     = RUN;
                    end else begin
                        f_stall   = 1'b1;
                        d_stall   = 1'b1;
                        e_stall   = 1'b1;
                        em_bubble = 1'b1;
                        if (md_done) begin
                            state_d = RUN;
                        end else if (md_cnt_q == MD_LAST) begin
                            md_abort = 1'b1;
                            md_err_d = 1'b1;
                            state_d  = RUN;
                        end else begin
                            md_cnt_d = md_cnt_q + 1'b1;
                        end
                    end
                end

                // Younger requests are held by their sources and re-evaluated in RUN.
                MEM_WAIT: begin
                    f_stall   = 1'b1;
                    d_stall   = 1'b1;
                    e_stall   = 1'b1;
                    m_stall   = 1'b1;
                    mw_bubble = 1'b1;
                    if (dmem_ready)
                        state_d = RUN;
                end

                // RUN and the unused encoding share the same priority chain.
                default: begin
                    state_d = RUN;
                    if (dmem_req && !dmem_ready) begin
                        f_stall   = 1'b1;
                        d_stall   = 1'b1;
                        e_stall   = 1'b1;
                        m_stall   = 1'b1;
                        mw_bubble = 1'b1;
                        state_d   = MEM_WAIT;
                    end else if (trap) begin
                        pc_redirect = 1'b1;
                        redirect_pc = trap_vec;
                        fd_flush    = 1'b1;
                        de_flush    = 1'b1;
                        em_bubble   = 1'b1;
                    end else if (md_start && !md_done) begin
                        f_stall   = 1'b1;
                        d_stall   = 1'b1;
                        e_stall   = 1'b1;
                        em_bubble = 1'b1;
                        md_cnt_d  = MD_W'(1);
                        state_d   = MD_WAIT;
                    end else if (br_taken) begin
                        pc_redirect = 1'b1;
                        redirect_pc = br_target;
                        fd_flush    = 1'b1;
                        de_flush    = 1'b1;
                    end else if (ld_use) begin
                        f_stall  = 1'b1;
                        d_stall  = 1'b1;
                        de_flush = 1'b1;
                    end
                end
            endcase
        end
    end

    assign state  = state_q;
    assign md_err = md_err_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: directed cycles push expected outputs, a
// negedge monitor pops and compares. A second instance covers timeout/saturation.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ld_use = 1'b0, br_taken = 1'b0, md_start = 1'b0, md_done = 1'b0;
    logic        dmem_req = 1'b0, dmem_ready = 1'b0, trap = 1'b0;
    logic [31:0] br_target = '0, trap_vec = '0;

    always #5 clk = ~clk;

    // Instance 0: default parameters. Instance 1: short timeout, 3-bit counter.
    logic        a_f, a_d, a_e, a_m, a_fd, a_de, a_em, a_mw, a_pcr, a_ab, a_err;
    logic [31:0] a_rpc, a_cnt;
    logic [1:0]  a_st;
    logic        b_f, b_d, b_e, b_m, b_fd, b_de, b_em, b_mw, b_pcr, b_ab, b_err;
    logic [31:0] b_rpc;
    logic [2:0]  b_cnt;
    logic [1:0]  b_st;

    pipe_ctrl dut (
        .clk(clk), .rst_n(rst_n), .ld_use(ld_use), .br_taken(br_taken),
        .br_target(br_target), .md_start(md_start), .md_done(md_done),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready), .trap(trap), .trap_vec(trap_vec),
        .f_stall(a_f), .d_stall(a_d), .e_stall(a_e), .m_stall(a_m),
        .fd_flush(a_fd), .de_flush(a_de), .em_bubble(a_em), .mw_bubble(a_mw),
        .pc_redirect(a_pcr), .redirect_pc(a_rpc), .md_abort(a_ab), .md_err(a_err),
        .state(a_st), .stall_cnt(a_cnt)
    );

    pipe_ctrl #(.MD_TIMEOUT(4), .CNT_W(3)) dut_to (
        .clk(clk), .rst_n(rst_n), .ld_use(ld_use), .br_taken(br_taken),
        .br_target(br_target), .md_start(md_start), .md_done(md_done),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready), .trap(trap), .trap_vec(trap_vec),
        .f_stall(b_f), .d_stall(b_d), .e_stall(b_e), .m_stall(b_m),
        .fd_flush(b_fd), .de_flush(b_de), .em_bubble(b_em), .mw_bubble(b_mw),
        .pc_redirect(b_pcr), .redirect_pc(b_rpc), .md_abort(b_ab), .md_err(b_err),
        .state(b_st), .stall_cnt(b_cnt)
    );

    // Input masks: {rst_n, ld_use, br_taken, md_start, md_done, dmem_req, dmem_ready, trap}
    localparam logic [7:0] RN = 8'h80, LD = 8'h40, BR = 8'h20, MS = 8'h10;
    localparam logic [7:0] MDN = 8'h08, DR = 8'h04, DY = 8'h02, TP = 8'h01;

    // Control vectors: {f, d, e, m, fd, de, em, mw, pc_redirect, md_abort}
    localparam logic [9:0] C_IDLE  = 10'b0000_0000_00;
    localparam logic [9:0] C_LDUSE = 10'b1100_0100_00;
    localparam logic [9:0] C_BR    = 10'b0000_1100_10;
    localparam logic [9:0] C_MD    = 10'b1110_0010_00;
    localparam logic [9:0] C_MDAB  = 10'b1110_0010_01;
    localparam logic [9:0] C_MEM   = 10'b1111_0001_00;
    localparam logic [9:0] C_TRAP  = 10'b0000_1110_10;
    localparam logic [9:0] C_TRAB  = 10'b0000_1110_11;

    typedef struct {
        bit          sel;
        logic [9:0]  ctrl;
        logic [31:0] rpc;
        logic [1:0]  st;
        logic        err;
        logic [31:0] cnt;
        int          id;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc_id = 0;

    task automatic cyc(input logic [7:0] in, input logic [31:0] bt, input logic [31:0] tv,
                       input bit sel, input logic [9:0] ctrl, input logic [31:0] rpc,
                       input logic [1:0] st, input logic err, input logic [31:0] cnt);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n      = in[7];
        ld_use     = in[6];
        br_taken   = in[5];
        md_start   = in[4];
        md_done    = in[3];
        dmem_req   = in[2];
        dmem_ready = in[1];
        trap       = in[0];
        br_target  = bt;
        trap_vec   = tv;
        e.sel = sel; e.ctrl = ctrl; e.rpc = rpc; e.st = st; e.err = err; e.cnt = cnt;
        e.id  = cyc_id;
        cyc_id++;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t        e;
            logic [9:0]  act_ctrl;
            logic [31:0] act_rpc, act_cnt;
            logic [1:0]  act_st;
            logic        act_err;
            e = sb.pop_front();
            if (e.sel) begin
                act_ctrl = {b_f, b_d, b_e, b_m, b_fd, b_de, b_em, b_mw, b_pcr, b_ab};
                act_rpc  = b_rpc;
                act_st   = b_st;
                act_err  = b_err;
                act_cnt  = {29'd0, b_cnt};
            end else begin
                act_ctrl = {a_f, a_d, a_e, a_m, a_fd, a_de, a_em, a_mw, a_pcr, a_ab};
                act_rpc  = a_rpc;
                act_st   = a_st;
                act_err  = a_err;
                act_cnt  = a_cnt;
            end
            checks++;
            if (act_ctrl !== e.ctrl) begin
                failures++;
                $display("FAIL ctrl cyc=%0d dut=%0d got=%b want=%b", e.id, e.sel, act_ctrl, e.ctrl);
            end
            checks++;
            if (act_rpc !== e.rpc) begin
                failures++;
                $display("FAIL redirect_pc cyc=%0d dut=%0d got=%h want=%h", e.id, e.sel, act_rpc, e.rpc);
            end
            checks++;
            if ({act_st, act_err, act_cnt} !== {e.st, e.err, e.cnt}) begin
                failures++;
                $display("FAIL regs cyc=%0d dut=%0d got st=%0d err=%b cnt=%0d want st=%0d err=%b cnt=%0d",
                         e.id, e.sel, act_st, act_err, act_cnt, e.st, e.err, e.cnt);
            end
        end
    end

    // A memory request while E holds a mul/div op cannot occur in a legal pipeline.
    always @(negedge clk) begin
        if (rst_n && (a_st == 2'd1 || b_st == 2'd1))
            assert (!dmem_req) else $error("protocol error: dmem_req during MD_WAIT");
    end

    initial begin
        // Reset with requests active: everything forced low.
        cyc(LD | TP,       0, 32'h55, 0, C_IDLE, 0, 0, 0, 0);
        cyc(RN,            0, 0,      0, C_IDLE, 0, 0, 0, 0);

        // Load-use for one cycle.
        cyc(RN | LD,       0, 0, 0, C_LDUSE, 0, 0, 0, 0);
        cyc(RN,            0, 0, 0, C_IDLE,  0, 0, 0, 1);

        // Branch beats load-use.
        cyc(RN | BR | LD,  32'h80, 0, 0, C_BR,   32'h80, 0, 0, 1);
        cyc(RN,            0,      0, 0, C_IDLE, 0,      0, 0, 1);

        // Mul/div: start at cycle 0, done at cycle 4.
        cyc(RN | MS,       0, 0, 0, C_MD,   0, 0, 0, 1);
        cyc(RN | MS,       0, 0, 0, C_MD,   0, 1, 0, 2);
        cyc(RN | MS,       0, 0, 0, C_MD,   0, 1, 0, 3);
        cyc(RN | MS,       0, 0, 0, C_MD,   0, 1, 0, 4);
        cyc(RN | MS | MDN, 0, 0, 0, C_MD,   0, 1, 0, 5);
        cyc(RN,            0, 0, 0, C_IDLE, 0, 0, 0, 6);

        // Single-cycle mul/div falls through to load-use.
        cyc(RN | MS | MDN | LD, 0, 0, 0, C_LDUSE, 0, 0, 0, 6);
        cyc(RN,                 0, 0, 0, C_IDLE,  0, 0, 0, 7);

        // Memory wait with a branch held; redirect only after the access completes.
        cyc(RN | DR | BR,      32'h44, 0, 0, C_MEM,  0,      0, 0, 7);
        cyc(RN | DR | BR,      32'h44, 0, 0, C_MEM,  0,      2, 0, 8);
        cyc(RN | DR | BR,      32'h44, 0, 0, C_MEM,  0,      2, 0, 9);
        cyc(RN | DR | DY | BR, 32'h44, 0, 0, C_MEM,  0,      2, 0, 10);
        cyc(RN | BR,           32'h44, 0, 0, C_BR,   32'h44, 0, 0, 11);
        cyc(RN,                0,      0, 0, C_IDLE, 0,      0, 0, 11);

        // Trap in RUN beats mul/div start and branch.
        cyc(RN | TP | MS | BR, 32'h80, 32'h200, 0, C_TRAP, 32'h200, 0, 0, 11);
        cyc(RN,                0,      0,       0, C_IDLE, 0,       0, 0, 11);

        // Trap in the second MD_WAIT cycle aborts the op.
        cyc(RN | MS,      0, 0,       0, C_MD,   0,       0, 0, 11);
        cyc(RN | MS,      0, 0,       0, C_MD,   0,       1, 0, 12);
        cyc(RN | MS | TP, 0, 32'h100, 0, C_TRAB, 32'h100, 1, 0, 13);
        cyc(RN,           0, 0,       0, C_IDLE, 0,       0, 0, 13);

        // Reset asserted in the middle of a memory wait.
        cyc(RN | DR, 0, 0, 0, C_MEM,  0, 0, 0, 13);
        cyc(RN | DR, 0, 0, 0, C_MEM,  0, 2, 0, 14);
        cyc(DR,      0, 0, 0, C_IDLE, 0, 0, 0, 0);
        cyc(DR,      0, 0, 0, C_IDLE, 0, 0, 0, 0);
        cyc(RN,      0, 0, 0, C_IDLE, 0, 0, 0, 0);

        // Timeout with MD_TIMEOUT=4, then saturate the 3-bit stall counter.
        cyc(RN | MS, 0, 0, 1, C_MD,    0, 0, 0, 0);
        cyc(RN | MS, 0, 0, 1, C_MD,    0, 1, 0, 1);
        cyc(RN | MS, 0, 0, 1, C_MD,    0, 1, 0, 2);
        cyc(RN | MS, 0, 0, 1, C_MDAB,  0, 1, 0, 3);
        cyc(RN | LD, 0, 0, 1, C_LDUSE, 0, 0, 1, 4);
        cyc(RN | LD, 0, 0, 1, C_LDUSE, 0, 0, 1, 5);
        cyc(RN | LD, 0, 0, 1, C_LDUSE, 0, 0, 1, 6);
        cyc(RN | LD, 0, 0, 1, C_LDUSE, 0, 0, 1, 7);
        cyc(RN | LD, 0, 0, 1, C_LDUSE, 0, 0, 1, 7);
        cyc(RN,      0, 0, 1, C_IDLE,  0, 0, 1, 7);

        for (int i = 0; i < 10 && sb.size() > 0; i++)
            @(posedge clk);
        if (sb.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain pending=%0d want=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
